// File: rtl/seg7_scan_decoder.sv
// Recovers hex nibbles from a multiplexed, active-low 7-segment bus.
// Each digit commits after STABLE_COUNT identical samples; a scan-order FSM flags full frames.
module seg7_scan_decoder #(
    parameter int NUM_DIGITS   = 4,
    parameter int STABLE_COUNT = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    input  logic                    sample_en,
    output logic [4*NUM_DIGITS-1:0] hex_out,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    frame_valid,
    output logic                    err
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);
    localparam logic [3:0] SC = 4'(STABLE_COUNT);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t          state, state_n;
    logic [IW-1:0]   exp_idx, exp_idx_n;
    logic [6:0]      cand [NUM_DIGITS];
    logic [3:0]      cnt  [NUM_DIGITS];

    logic            onehot, upd, commit, same;
    logic [IW-1:0]   sel;
    logic [3:0]      cnt_n;
    logic [5:0]      dec;
    logic            legal, blank;
    logic [3:0]      nib;
    logic [NUM_DIGITS-1:0] dv_n;
    logic            frame_n, err_n;

    // Returns {legal_nibble, blank, nibble}; all-zero means an illegal pattern.
    function automatic logic [5:0] decode(input logic [6:0] p);
        case (p)
            7'b0000001: decode = {2'b10, 4'h0};
            7'b1001111: decode = {2'b10, 4'h1};
            7'b0010010: decode = {2'b10, 4'h2};
            7'b0000110: decode = {2'b10, 4'h3};
            7'b1001100: decode = {2'b10, 4'h4};
            7'b0100100: decode = {2'b10, 4'h5};
            7'b0100000: decode = {2'b10, 4'h6};
            7'b0001111: decode = {2'b10, 4'h7};
            7'b0000000: decode = {2'b10, 4'h8};
            7'b0000100: decode = {2'b10, 4'h9};
            7'b0001000: decode = {2'b10, 4'hA};
            7'b1100000: decode = {2'b10, 4'hB};
            7'b0110001: decode = {2'b10, 4'hC};
            7'b1000010: decode = {2'b10, 4'hD};
            7'b0110000: decode = {2'b10, 4'hE};
            7'b0111000: decode = {2'b10, 4'hF};
            7'b1111111: decode = {2'b01, 4'h0};
            default:    decode = 6'b000000;
        endcase
    endfunction

    assign onehot = (dig_sel != '0) && ((dig_sel & (dig_sel - NUM_DIGITS'(1))) == '0);
    assign upd    = sample_en & onehot;

    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (dig_sel[i]) sel = IW'(i);
        end
    end

    assign same   = (seg_in == cand[sel]);
    assign cnt_n  = !same ? 4'd1 : ((cnt[sel] >= SC) ? SC : cnt[sel] + 4'd1);
    assign commit = upd && (cnt_n == SC);
    assign dec    = decode(seg_in);
    assign legal  = dec[5];
    assign blank  = dec[4];
    assign nib    = dec[3:0];

    // digit_valid as it will be after this sample; the frame check needs it.
    always_comb begin
        dv_n = digit_valid;
        if (commit) dv_n[sel] = legal;
    end

    always_comb begin
        state_n   = state;
        exp_idx_n = exp_idx;
        frame_n   = 1'b0;
        err_n     = commit & ~legal & ~blank;
        if (sample_en && !onehot) begin
            err_n = 1'b1;
        end else if (upd) begin
            if (NUM_DIGITS == 1) begin
                frame_n = &dv_n;
            end else if (state == IDLE) begin
                if (sel == '0) begin
                    state_n   = SCAN;
                    exp_idx_n = IW'(1);
                end
            end else if (sel == exp_idx) begin
                if (sel == LAST) begin
                    state_n   = IDLE;
                    exp_idx_n = '0;
                    frame_n   = &dv_n;
                end else begin
                    exp_idx_n = exp_idx + 1'b1;
                end
            end else begin
                err_n = 1'b1;
                if (sel == '0) begin
                    state_n   = SCAN;
                    exp_idx_n = IW'(1);
                end else begin
                    state_n   = IDLE;
                    exp_idx_n = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                cand[i] <= 7'b1111111;
                cnt[i]  <= 4'd0;
            end
            hex_out     <= '0;
            digit_valid <= '0;
            frame_valid <= 1'b0;
            err         <= 1'b0;
            state       <= IDLE;
            exp_idx     <= '0;
        end else begin
            if (upd) begin
                cand[sel] <= seg_in;
                cnt[sel]  <= cnt_n;
                if (commit && legal) hex_out[{sel, 2'b00} +: 4] <= nib;
            end
            digit_valid <= dv_n;
            frame_valid <= frame_n;
            err         <= err_n;
            state       <= state_n;
            exp_idx     <= exp_idx_n;
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: behavioural model compared every cycle,
// plus literal expectations at the end of each scenario.
module tb_seg7_scan_decoder;

    localparam int N  = 4;
    localparam int SC = 3;

    localparam logic [6:0] P0  = 7'b0000001;
    localparam logic [6:0] P1  = 7'b1001111;
    localparam logic [6:0] P2  = 7'b0010010;
    localparam logic [6:0] P3  = 7'b0000110;
    localparam logic [6:0] P4  = 7'b1001100;
    localparam logic [6:0] BL  = 7'b1111111;
    localparam logic [6:0] ILL = 7'b1110000;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [6:0]      seg_in = 7'b1111111;
    logic [N-1:0]    dig_sel = '0;
    logic            sample_en = 1'b0;
    logic [4*N-1:0]  hex_out;
    logic [N-1:0]    digit_valid;
    logic            frame_valid;
    logic            err;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;
    int fv_seen = 0;
    int err_seen = 0;

    seg7_scan_decoder #(.NUM_DIGITS(N), .STABLE_COUNT(SC)) dut (
        .clk(clk), .rst(rst), .seg_in(seg_in), .dig_sel(dig_sel),
        .sample_en(sample_en), .hex_out(hex_out), .digit_valid(digit_valid),
        .frame_valid(frame_valid), .err(err)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [6:0]   pat_tab [16];
    logic [6:0]   m_cand  [N];
    int           m_cnt   [N];
    logic [15:0]  m_hex;
    logic [3:0]   m_dv;
    bit           m_fv, m_err;
    int           m_next;  // expected next digit, -1 when no frame is in progress

    initial begin
        pat_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    end

    function automatic int lookup(input logic [6:0] p);
        for (int n = 0; n < 16; n++) if (pat_tab[n] == p) return n;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_cand[i] = 7'b1111111;
            m_cnt[i]  = 0;
        end
        m_hex = '0; m_dv = '0; m_fv = 0; m_err = 0; m_next = -1;
    endtask

    task automatic model_step(input logic [N-1:0] ds, input logic [6:0] seg);
        int d;
        int n;
        logic [3:0] nv;
        m_fv = 0; m_err = 0;
        if ($countones(ds) != 1) begin
            m_err = 1;
            return;
        end
        d = 0;
        for (int i = 0; i < N; i++) if (ds[i]) d = i;
        if (seg == m_cand[d]) begin
            if (m_cnt[d] < SC) m_cnt[d]++;
        end else begin
            m_cand[d] = seg;
            m_cnt[d]  = 1;
        end
        if (m_cnt[d] == SC) begin
            n = lookup(seg);
            if (n >= 0) begin
                nv = n[3:0];
                m_hex[4*d +: 4] = nv;
                m_dv[d] = 1'b1;
            end else begin
                m_dv[d] = 1'b0;
                if (seg != 7'b1111111) m_err = 1;
            end
        end
        if (m_next == -1) begin
            if (d == 0) m_next = 1;
        end else if (d == m_next) begin
            if (d == N - 1) begin
                m_next = -1;
                if (m_dv == 4'hF) m_fv = 1;
            end else begin
                m_next++;
            end
        end else begin
            m_err  = 1;
            m_next = (d == 0) ? 1 : -1;
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else if (sample_en) model_step(dig_sel, seg_in);
        else begin
            m_fv = 0; m_err = 0;
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started && !rst) begin
            check("hex_out", hex_out, m_hex);
            check("digit_valid", 16'(digit_valid), 16'(m_dv));
            check("frame_valid", 16'(frame_valid), 16'(m_fv));
            check("err", 16'(err), 16'(m_err));
            if (frame_valid) fv_seen++;
            if (err) err_seen++;
        end
    end

    // ---------------- drivers ----------------
    task automatic drive(input logic [N-1:0] ds, input logic [6:0] seg);
        @(negedge clk);
        dig_sel = ds; seg_in = seg; sample_en = 1'b1;
    endtask

    task automatic idle();
        @(negedge clk);
        sample_en = 1'b0; dig_sel = '0;
        #1;
    endtask

    task automatic frame(input logic [6:0] s0, input logic [6:0] s1,
                         input logic [6:0] s2, input logic [6:0] s3);
        drive(4'b0001, s0);
        drive(4'b0010, s1);
        drive(4'b0100, s2);
        drive(4'b1000, s3);
        idle();
    endtask

    // ---------------- stimulus ----------------
    int fv0, er0;

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        started = 1'b1;
        #1;
        check("reset hex_out", hex_out, 16'h0000);
        check("reset digit_valid", 16'(digit_valid), 16'h0);
        check("reset frame_valid", 16'(frame_valid), 16'h0);
        check("reset err", 16'(err), 16'h0);

        // three frames of 1,2,3,4
        fv0 = fv_seen;
        frame(P1, P2, P3, P4);
        frame(P1, P2, P3, P4);
        check("no fv frames 1-2", 16'(fv_seen - fv0), 16'd0);
        frame(P1, P2, P3, P4);
        check("f3 hex_out", hex_out, 16'h4321);
        check("f3 digit_valid", 16'(digit_valid), 16'hF);
        check("f3 fv count", 16'(fv_seen - fv0), 16'd1);

        // illegal pattern on digit 2
        er0 = err_seen;
        frame(P1, P2, ILL, P4);
        frame(P1, P2, ILL, P4);
        check("ill f2 digit_valid", 16'(digit_valid), 16'hF);
        check("ill f2 err count", 16'(err_seen - er0), 16'd0);
        fv0 = fv_seen;
        frame(P1, P2, ILL, P4);
        check("ill f3 digit_valid", 16'(digit_valid), 16'hB);
        check("ill f3 err count", 16'(err_seen - er0), 16'd1);
        check("ill f3 fv count", 16'(fv_seen - fv0), 16'd0);

        // restore digit 2 while blanking digit 3
        er0 = err_seen; fv0 = fv_seen;
        repeat (3) frame(P1, P2, P3, BL);
        check("blank digit_valid", 16'(digit_valid), 16'h7);
        check("blank hex_out", hex_out, 16'h4321);
        check("blank err count", 16'(err_seen - er0), 16'd0);
        check("blank fv count", 16'(fv_seen - fv0), 16'd0);

        // restore digit 3, then out-of-order scan 0,2
        repeat (3) frame(P1, P2, P3, P4);
        check("restored digit_valid", 16'(digit_valid), 16'hF);
        er0 = err_seen;
        drive(4'b0001, P1);
        drive(4'b0100, P3);
        idle();
        check("order err count", 16'(err_seen - er0), 16'd1);
        fv0 = fv_seen;
        frame(P1, P2, P3, P4);
        check("order recover fv", 16'(fv_seen - fv0), 16'd1);

        // zero and multi-hot dig_sel
        er0 = err_seen;
        drive(4'b0000, P0);
        drive(4'b0110, P0);
        idle();
        check("bad sel err count", 16'(err_seen - er0), 16'd2);
        check("bad sel hex_out", hex_out, 16'h4321);
        check("bad sel digit_valid", 16'(digit_valid), 16'hF);
        fv0 = fv_seen;
        frame(P1, P2, P3, P4);
        check("bad sel state kept fv", 16'(fv_seen - fv0), 16'd1);

        // reset between digit 1 and digit 2
        drive(4'b0001, P1);
        drive(4'b0010, P2);
        @(posedge clk);
        #1;
        rst = 1'b1; sample_en = 1'b0; dig_sel = '0;
        #1;
        check("mid rst hex_out", hex_out, 16'h0000);
        check("mid rst digit_valid", 16'(digit_valid), 16'h0);
        check("mid rst frame_valid", 16'(frame_valid), 16'h0);
        check("mid rst err", 16'(err), 16'h0);
        @(negedge clk);
        rst = 1'b0;
        fv0 = fv_seen;
        repeat (3) frame(P0, P0, P0, P0);
        check("post rst hex_out", hex_out, 16'h0000);
        check("post rst digit_valid", 16'(digit_valid), 16'hF);
        check("post rst fv count", 16'(fv_seen - fv0), 16'd1);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
